// File: rtl/pulses_pkg.sv
// pulses_pkg: shared types and default widths for the pulse-sequencing blocks.
// Contents: sweep_state_t FSM encoding, default delay/point/shot widths.
// Saturating delay arithmetic is implemented in sweep_step_alu, sized by DW.
package pulses_pkg;

  localparam int DW_DEF = 16;  // delay width in clock cycles
  localparam int NW_DEF = 16;  // point-count width
  localparam int SW_DEF = 16;  // shots-per-point width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DWELL = 2'd2,
    FIN   = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/sweep_step_alu.sv
// sweep_step_alu: combinational saturating step of the sweep delay.
// Ports: base_i/step_i operands, result_o clamped result, sat_o set when clamped.
// SWEEP_BIDIR_EN adds dir_i: 1 subtracts the step and clamps at 0.
module sweep_step_alu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] base_i,
  input  logic [DW-1:0] step_i,
`ifdef SWEEP_BIDIR_EN
  input  logic          dir_i,
`endif
  output logic [DW-1:0] result_o,
  output logic          sat_o
);

  logic [DW:0] sum;

  always_comb begin
    sum      = {1'b0, base_i} + {1'b0, step_i};
    result_o = sum[DW-1:0];
    sat_o    = 1'b0;
`ifdef SWEEP_BIDIR_EN
    if (dir_i) begin
      if (step_i > base_i) begin
        result_o = '0;
        sat_o    = 1'b1;
      end else begin
        result_o = base_i - step_i;
      end
    end else if (sum[DW]) begin
      result_o = '1;
      sat_o    = 1'b1;
    end
`else
    // Carry out of the DW-bit add means the delay would wrap: clamp instead.
    if (sum[DW]) begin
      result_o = '1;
      sat_o    = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/delay_sweep_sequencer.sv
// delay_sweep_sequencer: steps the pulse-generator echo delay through a linear sweep.
// Inputs: start/abort requests, cfg_start/step/points/shots, period_tick from pulse timing.
// Outputs: del_out + one-cycle load strobe on a period boundary, point_idx, busy, done, sat.
// Optional: SWEEP_BIDIR_EN adds cfg_dir (1 = decrementing sweep), latched on accept.
module delay_sweep_sequencer
  import pulses_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_step,
  input  logic [NW-1:0] cfg_points,
  input  logic [SW-1:0] cfg_shots,
`ifdef SWEEP_BIDIR_EN
  input  logic          cfg_dir,
`endif
  input  logic          period_tick,
  output logic [DW-1:0] del_out,
  output logic          load,
  output logic [NW-1:0] point_idx,
  output logic          busy,
  output logic          done,
  output logic          sat
);

  sweep_state_t  state_q, state_d;
  logic [DW-1:0] del_q, del_d, step_q, step_d;
  logic [NW-1:0] idx_q, idx_d, pts_q, pts_d;
  logic [SW-1:0] shot_q, shot_d, shots_q, shots_d;
  logic          load_q, load_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic [DW-1:0] alu_result;
  logic          alu_sat;
`ifdef SWEEP_BIDIR_EN
  logic          dir_q, dir_d;
`endif

  sweep_step_alu #(.DW(DW)) u_alu (
    .base_i   (del_q),
    .step_i   (step_q),
`ifdef SWEEP_BIDIR_EN
    .dir_i    (dir_q),
`endif
    .result_o (alu_result),
    .sat_o    (alu_sat)
  );

  always_comb begin
    state_d = state_q;
    del_d   = del_q;
    step_d  = step_q;
    idx_d   = idx_q;
    pts_d   = pts_q;
    shot_d  = shot_q;
    shots_d = shots_q;
    busy_d  = busy_q;
    sat_d   = sat_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SWEEP_BIDIR_EN
    dir_d   = dir_q;
`endif

    unique case (state_q)
      IDLE: begin
        // A tick coincident with the accepting start is not counted: ARM
        // only looks at ticks from the following cycle on.
        if (start && !abort) begin
          busy_d = 1'b1;
          if (cfg_points != '0 && cfg_shots != '0) begin
            del_d   = cfg_start;
            step_d  = cfg_step;
            pts_d   = cfg_points;
            shots_d = cfg_shots;
            idx_d   = '0;
            shot_d  = '0;
            sat_d   = 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_d   = cfg_dir;
`endif
            state_d = ARM;
          end else begin
            state_d = FIN;
          end
        end
      end
      ARM: begin
        if (period_tick) begin
          load_d  = 1'b1;
          shot_d  = '0;
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (period_tick) begin
          if (shot_q < shots_q - SW'(1)) begin
            shot_d = shot_q + SW'(1);
          end else if (idx_q == pts_q - NW'(1)) begin
            state_d = FIN;
          end else begin
            idx_d  = idx_q + NW'(1);
            del_d  = alu_result;
            sat_d  = sat_q | alu_sat;
            shot_d = '0;
            load_d = 1'b1;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above; the last delay stays on del_out.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      load_d  = 1'b0;
      done_d  = 1'b0;
      del_d   = del_q;
      idx_d   = idx_q;
      sat_d   = sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      del_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      pts_q   <= '0;
      shot_q  <= '0;
      shots_q <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      del_q   <= del_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      pts_q   <= pts_d;
      shot_q  <= shot_d;
      shots_q <= shots_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
`ifdef SWEEP_BIDIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign del_out   = del_q;
  assign load      = load_q;
  assign point_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat       = sat_q;

endmodule
